// File: rtl/ecc_ram_stream_ctrl_if.sv
// rtl/ecc_ram_stream_ctrl_if.sv - command, stream, status and operand-RAM signals of ecc_ram_stream_ctrl
// master: the controller's view; slave: the datapath/host and RAM side.
interface ecc_ram_stream_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  busy;
  logic                  done;
  logic                  done_err;
  logic                  ram_ena;
  logic                  ram_wea;
  logic [ADDR_WIDTH-1:0] ram_addra;
  logic [DATA_WIDTH-1:0] ram_douta;
  logic                  ram_enb;
  logic                  ram_web;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [DATA_WIDTH-1:0] ram_dinb;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, rd_ready, wr_data, wr_valid, ram_douta,
    output cmd_ready, rd_data, rd_valid, rd_last, wr_ready, busy, done, done_err,
           ram_ena, ram_wea, ram_addra, ram_enb, ram_web, ram_addrb, ram_dinb
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, rd_ready, wr_data, wr_valid, ram_douta,
    input  cmd_ready, rd_data, rd_valid, rd_last, wr_ready, busy, done, done_err,
           ram_ena, ram_wea, ram_addra, ram_enb, ram_web, ram_addrb, ram_dinb
  );
endinterface

// File: rtl/ecc_ram_stream_ctrl.sv
// rtl/ecc_ram_stream_ctrl.sv - block read/write/zeroize controller for the dual-port ECC operand RAM
// Zeroize (op 10) is built only when ECC_RAM_ZEROIZE_EN is defined; otherwise op 10 is rejected like op 11.
module ecc_ram_stream_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ecc_ram_stream_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_ZERO  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int CW = ADDR_WIDTH + 1;

`ifdef ECC_RAM_ZEROIZE_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         iss_left;
  logic [CW-1:0]         ret_left;
  logic                  err_q;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  issue, pop, wr_fire, step;

  assign pop     = bus.rd_valid && bus.rd_ready;
  assign wr_fire = (state == S_WRITE) && bus.wr_valid;
  assign step    = wr_fire || (state == S_ZERO);
  // A word popped this cycle frees its slot at the same edge, so it counts as credit for the next issue.
  assign issue   = (state == S_READ) && (iss_left != '0) &&
                   ({1'b0, fifo_cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      iss_left      <= '0;
      ret_left      <= '0;
      err_q         <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            iss_left <= {1'b0, bus.cmd_len} + CW'(1);
            ret_left <= {1'b0, bus.cmd_len} + CW'(1);
            err_q    <= 1'b0;
            case (bus.cmd_op)
              2'b00: state <= S_READ;
              2'b01: state <= S_WRITE;
              2'b10: begin
                if (ZERO_EN) begin
                  state <= S_ZERO;
                end else begin
                  state <= S_DONE;
                  err_q <= 1'b1;
                end
              end
              default: begin
                state <= S_DONE;
                err_q <= 1'b1;
              end
            endcase
          end
        end
        S_READ:          if (pop && ret_left == CW'(1)) state <= S_DONE;
        S_WRITE, S_ZERO: if (step && iss_left == CW'(1)) state <= S_DONE;
        default:         state <= S_IDLE;
      endcase

      if (issue || step) begin
        addr_q   <= addr_q + 1'b1;
        iss_left <= iss_left - CW'(1);
      end
      if (pop) begin
        ret_left <= ret_left - CW'(1);
        rd_ptr   <= ~rd_ptr;
      end

      // RAM read data is valid the cycle after the issue; capture it straight into the buffer.
      inflight      <= issue;
      inflight_last <= issue && (iss_left == CW'(1));
      if (inflight) begin
        fifo_data[wr_ptr] <= bus.ram_douta;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.done_err  = (state == S_DONE) && err_q;

  assign bus.rd_valid  = (fifo_cnt != 2'd0);
  assign bus.rd_data   = fifo_data[rd_ptr];
  assign bus.rd_last   = bus.rd_valid && fifo_last[rd_ptr];
  assign bus.wr_ready  = (state == S_WRITE);

  assign bus.ram_ena   = issue;
  assign bus.ram_wea   = 1'b0;
  assign bus.ram_addra = addr_q;
  assign bus.ram_enb   = step;
  assign bus.ram_web   = step;
  assign bus.ram_addrb = addr_q;
  assign bus.ram_dinb  = wr_fire ? bus.wr_data : '0;
endmodule

// File: tb/tb_ecc_ram_stream_ctrl.sv
// tb/tb_ecc_ram_stream_ctrl.sv - self-checking bench for ecc_ram_stream_ctrl with a behavioural RAM and block model
module tb_ecc_ram_stream_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef ECC_RAM_ZEROIZE_EN
  localparam int ZERO_WRITES = 2;
  localparam int ZERO_DONE_CYC = 2;
  localparam logic ZERO_ERR = 1'b0;
`else
  localparam int ZERO_WRITES = 0;
  localparam int ZERO_DONE_CYC = 0;
  localparam logic ZERO_ERR = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ecc_ram_stream_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ecc_ram_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Dual-port RAM with a registered port-A read.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (bus.ram_enb && bus.ram_web) ram[bus.ram_addrb] <= bus.ram_dinb;
    if (bus.ram_ena) bus.ram_douta <= ram[bus.ram_addra];
  end

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = -1, hs_cyc = 0, outstanding = 0;
  logic rd_active = 1'b0, rd_mode = 1'b0, prev_done = 1'b0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW:0]      exp_rd[$];
  logic             exp_err[$];
  int               pop_cyc[$];
  logic [DW-1:0]    pop_data[$];
  logic [AW-1:0]    wr_addr_log[$];
  logic [DW-1:0]    mem_model [1024];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of the DUT against the block-level expectations.
  initial begin
    logic [AW+DW-1:0] ew;
    logic [DW:0] er;
    int pop;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        outstanding = 0;
        prev_done = 1'b0;
        continue;
      end
      check("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
      check("ram_wea_zero", bus.ram_wea, 0);
      if (bus.ram_ena) check("ram_ena_only_in_read", rd_active, 1);
      if (bus.ram_enb) begin
        check("ram_web_with_enb", bus.ram_web, 1);
        wr_addr_log.push_back(bus.ram_addrb);
        if (exp_wr.size() == 0) check("unexpected_write", exp_wr.size(), 1);
        else begin
          ew = exp_wr.pop_front();
          check("wr_addr", bus.ram_addrb, ew[AW+DW-1:DW]);
          check("wr_data", bus.ram_dinb, ew[DW-1:0]);
        end
      end
      pop = (bus.rd_valid && bus.rd_ready) ? 1 : 0;
      if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop != 0) begin
        pop_cyc.push_back(cyc);
        pop_data.push_back(bus.rd_data);
        if (exp_rd.size() == 0) check("unexpected_read_word", exp_rd.size(), 1);
        else begin
          er = exp_rd.pop_front();
          check("rd_data", bus.rd_data, er[DW-1:0]);
          check("rd_last", bus.rd_last, er[DW]);
        end
      end
      outstanding += (bus.ram_ena ? 1 : 0) - pop;
      if (bus.ram_ena) check("outstanding_le_2", outstanding <= 2, 1);
      if (!bus.busy || bus.wr_ready) check("rd_valid_outside_read", bus.rd_valid, 0);
      if (bus.done) begin
        check("done_single_cycle", prev_done, 0);
        done_cnt++;
        done_cyc = cyc;
        if (exp_err.size() == 0) check("unexpected_done", exp_err.size(), 1);
        else check("done_err", bus.done_err, exp_err.pop_front());
      end else begin
        check("done_err_without_done", bus.done_err, 0);
      end
      prev_done = bus.done;
    end
  end

  // Read-side backpressure: always ready, or the repeating 1,0,0,1 pattern.
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_ready = rd_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
  end

  // Called at posedge+1 with the DUT idle; hs_cyc is the cycle that starts at the handshake edge.
  task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    check("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr = addr;
    bus.cmd_len = len;
    @(posedge clk);
    hs_cyc = cyc + 1;
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == start) check("done_timeout", done_cnt, start + 1);
  endtask

  task automatic write_block(input logic [AW-1:0] addr, input logic [AW-1:0] len, input logic [DW-1:0] base);
    int i = 0, n = 0, start;
    logic hs;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k <= int'(len); k++) begin
      a = AW'(int'(addr) + k);
      d = base + DW'(k);
      mem_model[a] = d;
      exp_wr.push_back({a, d});
    end
    exp_err.push_back(1'b0);
    wr_addr_log.delete();
    start = done_cnt;
    issue_cmd(2'b01, addr, len);
    bus.wr_valid = 1'b1;
    bus.wr_data = base;
    while (i <= int'(len) && n < 3000) begin
      @(negedge clk);
      hs = bus.wr_ready;
      @(posedge clk);
      #1;
      n++;
      if (hs) begin
        i++;
        bus.wr_data = base + DW'(i);
      end
    end
    bus.wr_valid = 1'b0;
    wait_done(start);
    check("write_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic read_block(input logic [AW-1:0] addr, input logic [AW-1:0] len, input logic mode);
    int start;
    logic [AW-1:0] a;
    for (int k = 0; k <= int'(len); k++) begin
      a = AW'(int'(addr) + k);
      exp_rd.push_back({k == int'(len), mem_model[a]});
    end
    exp_err.push_back(1'b0);
    rd_mode = mode;
    rd_active = 1'b1;
    first_valid_cyc = -1;
    pop_cyc.delete();
    pop_data.delete();
    start = done_cnt;
    issue_cmd(2'b00, addr, len);
    wait_done(start);
    rd_active = 1'b0;
    rd_mode = 1'b0;
    check("read_queue_drained", exp_rd.size(), 0);
    if (!mode && pop_cyc.size() == int'(len) + 1) begin
      check("first_valid_latency", first_valid_cyc - hs_cyc, 2);
      check("read_full_throughput", pop_cyc[len] - pop_cyc[0], len);
    end
  endtask

  task automatic check_words(input string name, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int cnt);
    logic [DW-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    check({name, "_count"}, pop_data.size(), cnt);
    for (int k = 0; k < cnt && k < pop_data.size(); k++) check(name, pop_data[k], w[k]);
  endtask

  initial begin
    int start, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.wr_data = '0;
    bus.wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_ram_ena", bus.ram_ena, 0);
    check("reset_ram_enb", bus.ram_enb, 0);
    check("reset_done", bus.done, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    write_block(10'h010, 10'd3, 32'hA0);
    check("write_addr0", wr_addr_log[0], 10'h010);
    check("write_addr3", wr_addr_log[3], 10'h013);
    read_block(10'h010, 10'd3, 1'b0);
    check_words("read_a_ready", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
    read_block(10'h010, 10'd3, 1'b1);
    check_words("read_a_backpressure", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);

    write_block(10'h3FE, 10'd3, 32'hB0);
    check("wrap_addr1", wr_addr_log[1], 10'h3FF);
    check("wrap_addr2", wr_addr_log[2], 10'h000);
    check("wrap_addr3", wr_addr_log[3], 10'h001);
    read_block(10'h3FE, 10'd3, 1'b1);
    check_words("read_wrap", 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4);

`ifdef ECC_RAM_ZEROIZE_EN
    for (int k = 0; k < 2; k++) begin
      mem_model[16 + k] = '0;
      exp_wr.push_back({AW'(16 + k), DW'(0)});
    end
`endif
    exp_err.push_back(ZERO_ERR);
    wr_addr_log.delete();
    start = done_cnt;
    issue_cmd(2'b10, 10'h010, 10'd1);
    wait_done(start);
    check("zero_write_count", wr_addr_log.size(), ZERO_WRITES);
    check("zero_done_cycle", done_cyc - hs_cyc, ZERO_DONE_CYC);
    read_block(10'h010, 10'd1, 1'b0);
`ifdef ECC_RAM_ZEROIZE_EN
    check_words("zero_readback", 32'h0, 32'h0, 32'h0, 32'h0, 2);
`else
    check_words("zero_rejected_readback", 32'hA0, 32'hA1, 32'h0, 32'h0, 2);
`endif

    exp_err.push_back(1'b1);
    wr_addr_log.delete();
    start = done_cnt;
    issue_cmd(2'b11, 10'h020, 10'd5);
    wait_done(start);
    check("reserved_done_next_cycle", done_cyc - hs_cyc, 0);
    check("reserved_no_write", wr_addr_log.size(), 0);

    // Abort a read with reset while its second word is on the stream.
    for (int k = 0; k < 4; k++) exp_rd.push_back({k == 3, mem_model[AW'(16 + k)]});
    rd_active = 1'b1;
    pop_cyc.delete();
    issue_cmd(2'b00, 10'h010, 10'd3);
    n = 0;
    while (pop_cyc.size() < 1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_first_word_seen", pop_cyc.size() >= 1, 1);
    reset_n = 1'b0;
    #1;
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_ram_ena", bus.ram_ena, 0);
    check("abort_ram_enb", bus.ram_enb, 0);
    check("abort_done", bus.done, 0);
    check("abort_rd_data", bus.rd_data, 0);
    exp_rd.delete();
    rd_active = 1'b0;
    start = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done_pulse", done_cnt, start);
    read_block(10'h3FE, 10'd3, 1'b0);
    check_words("read_after_abort", 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
